// File: rtl/compression_scheduler_pkg.sv
// Shared definitions for the compression scheduler: parameter defaults,
// width helpers and the drain-event classification used by the top level.
package compression_scheduler_pkg;

  localparam int DEF_NUM_STREAM_ELEMENTS      = 4;
  localparam int DEF_NUM_COMPRESSION_ELEMENTS = 2;
  localparam int DEF_MAX_UNCOMPRESSED_BYTES   = 34;

  // Bits needed to hold a record length from 0 up to maxBytes inclusive.
  function automatic int byteCountWidth(input int maxBytes);
    return $clog2(maxBytes + 1);
  endfunction

  // Bits needed to select one of n items, never less than one bit.
  function automatic int selWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // What a cycle's ce_drained pattern means to the order queue.
  typedef enum logic [1:0] {
    DRAIN_NONE,
    DRAIN_POP,
    DRAIN_ERROR
  } drainAction_e;

endpackage

// File: rtl/compression_scheduler_if.sv
// Bundle of request, engine-routing and return-FIFO signals between the
// scheduler (master) and the stream elements / engines / FIFO (slave).
interface compression_scheduler_if #(
  parameter int NUM_STREAM_ELEMENTS      = compression_scheduler_pkg::DEF_NUM_STREAM_ELEMENTS,
  parameter int NUM_COMPRESSION_ELEMENTS = compression_scheduler_pkg::DEF_NUM_COMPRESSION_ELEMENTS,
  parameter int MAX_UNCOMPRESSED_BYTES   = compression_scheduler_pkg::DEF_MAX_UNCOMPRESSED_BYTES
);
  import compression_scheduler_pkg::*;

  localparam int NSE = NUM_STREAM_ELEMENTS;
  localparam int NCE = NUM_COMPRESSION_ELEMENTS;
  localparam int CW  = byteCountWidth(MAX_UNCOMPRESSED_BYTES);
  localparam int SW  = selWidth(NSE);
  localparam int FSW = selWidth(NCE);

  logic [NSE-1:0][CW-1:0] use_byte_count;
  logic [NSE-1:0]         use_taken;
  logic [NCE-1:0][SW-1:0] route_sel;
  logic [NCE-1:0]         ce_load;
  logic [NCE-1:0]         ce_busy;
  logic [NCE-1:0]         ce_out_valid;
  logic [NCE-1:0]         ce_drained;
  logic [FSW-1:0]         fifo_sel;
  logic                   fifo_data_valid;
  logic                   fifo_shift;
  logic [NCE-1:0]         ce_shift;
  logic                   order_error;

  modport master (
    input  use_byte_count, ce_busy, ce_out_valid, ce_drained, fifo_shift,
    output use_taken, route_sel, ce_load, fifo_sel, fifo_data_valid, ce_shift, order_error
  );

  modport slave (
    output use_byte_count, ce_busy, ce_out_valid, ce_drained, fifo_shift,
    input  use_taken, route_sel, ce_load, fifo_sel, fifo_data_valid, ce_shift, order_error
  );

endinterface

// File: rtl/compression_scheduler_sched_order_queue.sv
// Small circular FIFO remembering which engine was loaded in which order,
// so compressed output is returned in dispatch order. Simultaneous push and
// pop are both honoured, including when the queue is full.
module sched_order_queue
  import compression_scheduler_pkg::*;
#(
  parameter int DEPTH = DEF_NUM_COMPRESSION_ELEMENTS,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_pushData,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty
);

  localparam int PW   = selWidth(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rdPtr;
  logic [PW-1:0]    r_wrPtr;
  logic [CNTW-1:0]  r_count;
  logic             w_full;
  logic             w_doPop;
  logic             w_doPush;

  function automatic logic [PW-1:0] advance(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign o_empty  = (r_count == '0);
  assign w_full   = (r_count == CNTW'(DEPTH));
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!w_full || w_doPop);
  assign o_head   = o_empty ? '0 : r_mem[r_rdPtr];

  // Advance read/write pointers and track occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= advance(r_wrPtr);
      if (w_doPop)  r_rdPtr <= advance(r_rdPtr);
      if (w_doPush && !w_doPop)
        r_count <= r_count + 1'b1;
      else if (w_doPop && !w_doPush)
        r_count <= r_count - 1'b1;
    end
  end

  // Entry storage needs no reset; occupancy decides what is meaningful.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_pushData;
  end

endmodule

// File: rtl/compression_scheduler.sv
// Hands pending records from the stream elements to the shared compression
// engines in strict ring order, then returns the compressed bytes to the
// output FIFO in the same order the records were dispatched.
module compression_scheduler
  import compression_scheduler_pkg::*;
#(
  parameter int NUM_STREAM_ELEMENTS      = DEF_NUM_STREAM_ELEMENTS,
  parameter int NUM_COMPRESSION_ELEMENTS = DEF_NUM_COMPRESSION_ELEMENTS,
  parameter int MAX_UNCOMPRESSED_BYTES   = DEF_MAX_UNCOMPRESSED_BYTES
) (
  input logic                    clk,
  input logic                    reset,
  compression_scheduler_if.master bus
);

  localparam int NSE = NUM_STREAM_ELEMENTS;
  localparam int NCE = NUM_COMPRESSION_ELEMENTS;
  localparam int CW  = byteCountWidth(MAX_UNCOMPRESSED_BYTES);
  localparam int SW  = selWidth(NSE);
  localparam int FSW = selWidth(NCE);

  logic [SW-1:0]          r_nextSe;
  logic [NSE-1:0]         r_takeMask;
  logic [NCE-1:0]         r_reserved;
  logic [NSE-1:0]         r_useTaken;
  logic [NCE-1:0]         r_ceLoad;
  logic [NCE-1:0][SW-1:0] r_routeSel;
  logic                   r_orderError;

  logic [NCE-1:0] w_free;
  logic           w_anyFree;
  logic [FSW-1:0] w_freeIdx;
  logic           w_dispatch;
  logic [FSW-1:0] w_head;
  logic           w_empty;
  drainAction_e   w_drainAction;
  logic           w_pop;
  logic           w_fifoValid;
  logic [NCE-1:0] w_ceShift;

  // An engine freed by a drain this cycle is still reserved here, so it can
  // only be picked up again on the following cycle.
  assign w_free    = ~r_reserved & ~bus.ce_busy;
  assign w_anyFree = |w_free;

  // Pick the lowest-index free engine.
  always_comb begin
    w_freeIdx = '0;
    for (int c = NCE - 1; c >= 0; c--) begin
      if (w_free[c]) w_freeIdx = FSW'(c);
    end
  end

  // Only the element under the ring pointer may go; a held record that was
  // already taken is masked until its count returns to zero.
  assign w_dispatch = (bus.use_byte_count[r_nextSe] != CW'(0)) &&
                      !r_takeMask[r_nextSe] && w_anyFree;

  // Classify drain pulses: a lone pulse from the queue head pops, anything
  // else is a protocol violation that leaves the queue untouched.
  always_comb begin
    w_drainAction = DRAIN_NONE;
    if (bus.ce_drained != '0) begin
      if ($onehot(bus.ce_drained) && !w_empty &&
          bus.ce_drained[w_head] && r_reserved[w_head])
        w_drainAction = DRAIN_POP;
      else
        w_drainAction = DRAIN_ERROR;
    end
  end

  assign w_pop = (w_drainAction == DRAIN_POP);

  sched_order_queue #(
    .DEPTH (NCE),
    .WIDTH (FSW)
  ) u_orderQueue (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_dispatch),
    .i_pushData (w_freeIdx),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_empty    (w_empty)
  );

  // Dispatch bookkeeping, engine reservations and the sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_nextSe     <= '0;
      r_takeMask   <= '0;
      r_reserved   <= '0;
      r_useTaken   <= '0;
      r_ceLoad     <= '0;
      r_routeSel   <= '0;
      r_orderError <= 1'b0;
    end else begin
      r_useTaken <= '0;
      r_ceLoad   <= '0;
      for (int s = 0; s < NSE; s++) begin
        if (bus.use_byte_count[s] == CW'(0)) r_takeMask[s] <= 1'b0;
      end
      if (w_pop) r_reserved[w_head] <= 1'b0;
      if (w_drainAction == DRAIN_ERROR) r_orderError <= 1'b1;
      if (w_dispatch) begin
        r_useTaken[r_nextSe]  <= 1'b1;
        r_takeMask[r_nextSe]  <= 1'b1;
        r_ceLoad[w_freeIdx]   <= 1'b1;
        r_reserved[w_freeIdx] <= 1'b1;
        r_routeSel[w_freeIdx] <= r_nextSe;
        r_nextSe <= (r_nextSe == SW'(NSE - 1)) ? '0 : r_nextSe + 1'b1;
      end
    end
  end

  assign w_fifoValid = !w_empty && bus.ce_out_valid[w_head];

  // Forward the FIFO shift only to the engine currently at the queue head.
  always_comb begin
    w_ceShift         = '0;
    w_ceShift[w_head] = bus.fifo_shift && w_fifoValid;
  end

  assign bus.use_taken       = r_useTaken;
  assign bus.ce_load         = r_ceLoad;
  assign bus.route_sel       = r_routeSel;
  assign bus.order_error     = r_orderError;
  assign bus.fifo_sel        = w_head;
  assign bus.fifo_data_valid = w_fifoValid;
  assign bus.ce_shift        = w_ceShift;

endmodule

// File: tb/tb_compression_scheduler.sv
// Bench for compression_scheduler: directed scenarios followed by random
// traffic, all compared every cycle against a queue-based reference model.
module tb_compression_scheduler;
  import compression_scheduler_pkg::*;

  localparam int NSE  = 4;
  localparam int NCE  = 2;
  localparam int MAXB = 34;
  localparam int CW   = byteCountWidth(MAXB);

  logic clk;
  logic reset;

  compression_scheduler_if #(
    .NUM_STREAM_ELEMENTS      (NSE),
    .NUM_COMPRESSION_ELEMENTS (NCE),
    .MAX_UNCOMPRESSED_BYTES   (MAXB)
  ) bus ();

  compression_scheduler #(
    .NUM_STREAM_ELEMENTS      (NSE),
    .NUM_COMPRESSION_ELEMENTS (NCE),
    .MAX_UNCOMPRESSED_BYTES   (MAXB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors;
  int checks;

  // Reference model state: ring pointer, take mask, queue of engines in
  // dispatch order (an engine is reserved exactly while it is in the queue).
  int             mNextSe;
  bit [NSE-1:0]   mTake;
  int             mQ[$];
  bit             mErr;
  bit [NSE-1:0]   expTaken;
  bit [NCE-1:0]   expLoad;
  int             expRoute[NCE];

  bit [NSE-1:0]   tbTaken;
  bit [NSE-1:0]   holdEl;
  int             taken1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic bit inQueue(input int eng);
    foreach (mQ[i]) if (mQ[i] == eng) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelReset();
    mNextSe = 0;
    mTake = '0;
    mQ.delete();
    mErr = 1'b0;
    expTaken = '0;
    expLoad = '0;
    foreach (expRoute[c]) expRoute[c] = 0;
  endtask

  task automatic zeroInputs();
    bus.use_byte_count = '0;
    bus.ce_busy = '0;
    bus.ce_out_valid = '0;
    bus.ce_drained = '0;
    bus.fifo_shift = 1'b0;
  endtask

  task automatic setCounts(input int a, input int b, input int c, input int d);
    bus.use_byte_count[0] = CW'(a);
    bus.use_byte_count[1] = CW'(b);
    bus.use_byte_count[2] = CW'(c);
    bus.use_byte_count[3] = CW'(d);
  endtask

  // One clock: check combinational outputs, advance the model, then check
  // registered outputs half a cycle after the edge.
  task automatic tick();
    int head;
    int nd;
    int eng;
    bit pop;
    bit found;
    bit disp;
    bit expValid;
    #1;
    head = (mQ.size() > 0) ? mQ[0] : 0;
    expValid = (mQ.size() > 0) && (bus.ce_out_valid[head] == 1'b1);
    checkOutput("fifo_sel", bus.fifo_sel, head);
    checkOutput("fifo_data_valid", bus.fifo_data_valid, expValid);
    checkOutput("ce_shift", bus.ce_shift, (expValid && bus.fifo_shift) ? (1 << head) : 0);
    if (reset) begin
      modelReset();
    end else begin
      nd = $countones(bus.ce_drained);
      pop = (nd == 1) && (mQ.size() > 0) && bus.ce_drained[head];
      if (nd > 0 && !pop) mErr = 1'b1;
      found = 1'b0;
      eng = 0;
      for (int c = 0; c < NCE; c++) begin
        if (!found && !inQueue(c) && !bus.ce_busy[c]) begin
          found = 1'b1;
          eng = c;
        end
      end
      disp = found && (bus.use_byte_count[mNextSe] != 0) && !mTake[mNextSe];
      expTaken = '0;
      expLoad = '0;
      for (int s = 0; s < NSE; s++) if (bus.use_byte_count[s] == 0) mTake[s] = 1'b0;
      if (pop) void'(mQ.pop_front());
      if (disp) begin
        expTaken[mNextSe] = 1'b1;
        expLoad[eng] = 1'b1;
        expRoute[eng] = mNextSe;
        mTake[mNextSe] = 1'b1;
        mQ.push_back(eng);
        mNextSe = (mNextSe + 1) % NSE;
      end
    end
    @(negedge clk);
    checkOutput("use_taken", bus.use_taken, expTaken);
    checkOutput("ce_load", bus.ce_load, expLoad);
    for (int c = 0; c < NCE; c++) checkOutput("route_sel", bus.route_sel[c], expRoute[c]);
    checkOutput("order_error", bus.order_error, mErr);
    tbTaken |= expTaken;
  endtask

  task automatic doReset();
    zeroInputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tbTaken = '0;
  endtask

  // Random environment: requesters drop a taken record after a while and
  // raise new ones, engines drain in queue order, optional illegal drains.
  task automatic applyStimulus(input int reqPct, input int drainPct, input int busyPct, input bit allowBad);
    for (int s = 0; s < NSE; s++) begin
      if (tbTaken[s] && !holdEl[s] && ($urandom_range(99) < 40)) begin
        bus.use_byte_count[s] = '0;
        tbTaken[s] = 1'b0;
      end else if (bus.use_byte_count[s] == '0 && ($urandom_range(99) < reqPct)) begin
        bus.use_byte_count[s] = CW'($urandom_range(MAXB, 1));
      end
    end
    for (int c = 0; c < NCE; c++) begin
      bus.ce_busy[c] = ($urandom_range(99) < busyPct);
      bus.ce_out_valid[c] = 1'($urandom_range(1));
    end
    bus.fifo_shift = 1'($urandom_range(1));
    bus.ce_drained = '0;
    if (mQ.size() > 0 && ($urandom_range(99) < drainPct)) bus.ce_drained[mQ[0]] = 1'b1;
    if (allowBad && ($urandom_range(99) < 4)) bus.ce_drained = NCE'($urandom_range(3));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    holdEl = '0;
    tbTaken = '0;
    reset = 1'b1;
    zeroInputs();
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_use_taken", bus.use_taken, 0);
    checkOutput("rst_ce_load", bus.ce_load, 0);
    checkOutput("rst_order_error", bus.order_error, 0);
    checkOutput("rst_fifo_data_valid", bus.fifo_data_valid, 0);

    // Single request from element 0, then element 1 proves the pointer moved.
    setCounts(5, 0, 0, 0);
    tick();
    checkOutput("d1_use_taken", bus.use_taken, 4'b0001);
    checkOutput("d1_ce_load", bus.ce_load, 2'b01);
    checkOutput("d1_route_sel0", bus.route_sel[0], 0);
    setCounts(7, 0, 0, 0);
    tick();
    checkOutput("d1_stall_on_el1", bus.use_taken, 0);
    setCounts(7, 3, 0, 0);
    tick();
    checkOutput("d1_el1_taken", bus.use_taken, 4'b0010);
    checkOutput("d1_el1_load", bus.ce_load, 2'b10);
    checkOutput("d1_route_sel1", bus.route_sel[1], 1);

    // All elements request with two engines: third waits for a drain.
    doReset();
    setCounts(1, 2, 3, 4);
    tick();
    checkOutput("d2_el0", bus.use_taken, 4'b0001);
    tick();
    checkOutput("d2_el1", bus.use_taken, 4'b0010);
    checkOutput("d2_el1_eng", bus.ce_load, 2'b10);
    tick();
    tick();
    checkOutput("d2_stall", bus.use_taken, 0);
    bus.ce_out_valid = 2'b01;
    bus.ce_drained = 2'b01;
    tick();
    checkOutput("d2_no_same_cycle_reuse", bus.use_taken, 0);
    bus.ce_drained = 2'b00;
    tick();
    checkOutput("d2_el2", bus.use_taken, 4'b0100);
    checkOutput("d2_el2_eng", bus.ce_load, 2'b01);
    checkOutput("d2_route_sel0", bus.route_sel[0], 2);

    // Engine 1 ready before engine 0: output still follows dispatch order.
    doReset();
    setCounts(1, 1, 0, 0);
    tick();
    tick();
    setCounts(0, 0, 0, 0);
    bus.ce_out_valid = 2'b10;
    bus.fifo_shift = 1'b1;
    #1;
    checkOutput("d3_sel_wait", bus.fifo_sel, 0);
    checkOutput("d3_valid_wait", bus.fifo_data_valid, 0);
    checkOutput("d3_shift_wait", bus.ce_shift, 0);
    tick();
    bus.ce_out_valid = 2'b11;
    #1;
    checkOutput("d3_valid_head0", bus.fifo_data_valid, 1);
    checkOutput("d3_shift_head0", bus.ce_shift, 2'b01);
    tick();
    bus.ce_drained = 2'b01;
    tick();
    bus.ce_drained = 2'b00;
    #1;
    checkOutput("d3_sel_head1", bus.fifo_sel, 1);
    checkOutput("d3_shift_head1", bus.ce_shift, 2'b10);
    tick();
    bus.ce_drained = 2'b10;
    tick();
    bus.ce_drained = 2'b00;
    bus.fifo_shift = 1'b0;
    tick();

    // Element 1 keeps its count up long after being taken, while the ring
    // keeps turning: it must be dispatched exactly once.
    doReset();
    holdEl = 4'b0010;
    taken1 = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(100, 100, 0, 1'b0);
      tick();
      if (bus.use_taken[1]) taken1++;
    end
    checkOutput("d4_el1_dispatches", taken1, 1);
    holdEl = '0;

    // Drain from a non-head engine, then reset in the middle of a transfer.
    doReset();
    setCounts(1, 1, 0, 0);
    tick();
    tick();
    setCounts(0, 0, 0, 0);
    bus.ce_drained = 2'b10;
    tick();
    checkOutput("d5_order_error", bus.order_error, 1);
    bus.ce_drained = 2'b00;
    bus.ce_out_valid = 2'b11;
    #1;
    checkOutput("d5_queue_head_kept", bus.fifo_sel, 0);
    checkOutput("d5_queue_valid_kept", bus.fifo_data_valid, 1);
    tick();
    setCounts(3, 3, 3, 3);
    bus.fifo_shift = 1'b1;
    reset = 1'b1;
    tick();
    #1;
    checkOutput("d5_rst_use_taken", bus.use_taken, 0);
    checkOutput("d5_rst_ce_load", bus.ce_load, 0);
    checkOutput("d5_rst_route_sel", bus.route_sel, 0);
    checkOutput("d5_rst_order_error", bus.order_error, 0);
    checkOutput("d5_rst_fifo_sel", bus.fifo_sel, 0);
    checkOutput("d5_rst_valid", bus.fifo_data_valid, 0);
    checkOutput("d5_rst_ce_shift", bus.ce_shift, 0);
    reset = 1'b0;
    zeroInputs();
    tick();

    // Random legal traffic.
    tbTaken = '0;
    for (int i = 0; i < 400; i++) begin
      applyStimulus(40, 30, 10, 1'b0);
      tick();
    end

    // Random traffic with occasional protocol violations.
    doReset();
    for (int i = 0; i < 200; i++) begin
      applyStimulus(50, 30, 10, 1'b1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/compression_scheduler.md
COMPRESSION_SCHEDULER -- requirements
Module: compression_scheduler

Interface
REQ-001 SHALL have parameter NUM_STREAM_ELEMENTS, default 4, number of stream-element requesters (min 2).
REQ-002 SHALL have parameter NUM_COMPRESSION_ELEMENTS, default 2, number of shared compression engines (min 1, max NUM_STREAM_ELEMENTS).
REQ-003 SHALL have parameter MAX_UNCOMPRESSED_BYTES, default 34, maximum record length.
REQ-004 SHALL have port clk, input, 1, clock; all logic on posedge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 SHALL have port use_byte_count, input, NSE x clog2(MAX_UNCOMPRESSED_BYTES+1), per-element pending record length; nonzero = request.
REQ-007 SHALL have port use_taken, output, NSE, one-cycle pulse; record accepted.
REQ-008 SHALL have port route_sel, output, NCE x clog2(NSE), stream element muxed into each compression element.
REQ-009 SHALL have port ce_load, output, NCE, one-cycle pulse; engine captures the routed record.
REQ-010 SHALL have port ce_busy, input, NCE, engine internally busy.
REQ-011 SHALL have port ce_out_valid, input, NCE, engine holds nonzero compressed bytes.
REQ-012 SHALL have port ce_drained, input, NCE, one-cycle pulse; last compressed byte of the record shifted out.
REQ-013 SHALL have port fifo_sel, output, clog2(NCE) (min 1), engine routed to the return FIFO.
REQ-014 SHALL have port fifo_data_valid, output, 1, selected engine has data.
REQ-015 SHALL have port fifo_shift, input, 1, return FIFO consumes bytes.
REQ-016 SHALL have port ce_shift, output, NCE, shift forwarded to the selected engine only.
REQ-017 SHALL have port order_error, output, 1, sticky protocol error.

Function
REQ-018 SHALL dispatch records strictly in ring order: pointer next_se visits 0,1,..,NSE-1,0; no element is skipped while its request is absent (in-order stall).
REQ-019 SHALL dispatch at cycle t when use_byte_count[next_se]!=0, take_mask[next_se]==0 and some engine is free (reserved==0 and ce_busy==0); the lowest-index free engine is chosen.
REQ-020 SHALL on dispatch register, visible at t+1: route_sel[c]=next_se, ce_load[c]=1, use_taken[next_se]=1; next_se increments modulo NSE; reserved[c] and take_mask[next_se] set.
REQ-021 SHALL perform at most one dispatch per cycle.
REQ-022 SHALL clear take_mask[s] on the first cycle use_byte_count[s]==0, preventing re-dispatch of a held record.
REQ-023 SHALL hold route_sel[c] stable from ce_load until ce_drained[c].
REQ-024 SHALL push each dispatched engine index into an order queue of depth NCE; queue cannot overflow since reserved engines never exceed NCE.
REQ-025 SHALL drive fifo_sel = queue head (0 when empty); fifo_data_valid = queue nonempty AND ce_out_valid[head], combinationally.
REQ-026 SHALL drive ce_shift[head] = fifo_shift AND fifo_data_valid; all other ce_shift bits 0.
REQ-027 SHALL on ce_drained[head] pop the queue and clear reserved[head]; the engine becomes eligible from the next cycle, never the same cycle.
REQ-028 SHALL set order_error on ce_drained for a non-head or unreserved engine, or simultaneous multiple ce_drained; the event is otherwise ignored.
REQ-029 SHALL allow dispatch and pop in the same cycle, queue push and pop both taking effect.

Reset
REQ-030 SHALL on reset clear next_se, take_mask, reserved, queue, order_error; all outputs 0 the following cycle.
REQ-031 SHALL on reset mid-operation abandon in-flight records without emitting further ce_load, use_taken or ce_shift.

Structure
REQ-032 SHALL place parameter defaults and the width function for byte counts in the shared compressor package.
REQ-033 SHALL implement the order queue as sub-module sched_order_queue (parameterised depth/width, push, pop, head, empty).

Verification
REQ-034 SHALL cover: reset, then counts {5,0,0,0} -> use_taken[0] and ce_load[0] at t+1, route_sel[0]=0, next_se=1.
REQ-035 SHALL cover: NCE=2, all four elements request -> elements 0,1 dispatched to engines 0,1 on consecutive cycles; element 2 stalls until first ce_drained, then goes to the freed engine next cycle.
REQ-036 SHALL cover: engine 1 ce_out_valid before engine 0 -> fifo_sel stays 0, fifo_data_valid 0 until engine 0 valid; output order matches dispatch order.
REQ-037 SHALL cover: element 1 holds nonzero count 3 cycles after use_taken -> exactly one dispatch for element 1.
REQ-038 SHALL cover: ce_drained[1] while head=0 -> order_error=1, queue unchanged; reset asserted mid-transfer -> all outputs 0 next cycle.
